// File: rtl/bs_decoder.sv
// USB receive bit-stream decoder: SYNC hunt, PID classification, payload deserialisation.
// Define BS_DEC_PID_CHECK_EN to reject PIDs whose upper nibble is not the complement of the lower.
module bs_decoder #(
  parameter logic [7:0]  SYNC_PAT  = 8'b00000001,
  parameter int unsigned TOK_BITS  = 11,
  parameter int unsigned DATA_BITS = 64,
  parameter int unsigned TOK_CRC   = 5,
  parameter int unsigned DATA_CRC  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_in,
  input  logic                  s_valid,
  input  logic                  eop,
  input  logic                  crc_ok,
  output logic                  crc_bit,
  output logic                  crc_en,
  output logic [1:0]            pkt_in,
  output logic [1:0]            pkt_type,
  output logic [TOK_BITS+7:0]   token,
  output logic [DATA_BITS+7:0]  data,
  output logic [7:0]            hshake,
  output logic                  pkt_valid,
  output logic                  pkt_err,
  output logic [1:0]            err_code,
  output logic                  busy
);

  typedef enum logic [1:0] {HUNT, PID, PAYLOAD, DRAIN} state_e;

  localparam logic [1:0] T_TOK   = 2'b01;
  localparam logic [1:0] T_DATA  = 2'b11;
  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CRC = 2'b10;
  localparam logic [1:0] ERR_PID = 2'b11;
  localparam logic [6:0] TOK_LEN  = 7'(TOK_BITS + TOK_CRC);
  localparam logic [6:0] DATA_LEN = 7'(DATA_BITS + DATA_CRC);
  localparam logic [6:0] TOK_PAY  = 7'(TOK_BITS);
  localparam logic [6:0] DATA_PAY = 7'(DATA_BITS);

  state_e                 state_q, state_d;
  logic [7:0]             win_q, win_d, win_sh;
  logic [6:0]             cnt_q, cnt_d;
  logic [7:0]             pid_q, pid_d, pid_sh;
  logic [DATA_BITS-1:0]   pay_q, pay_d;
  logic [1:0]             err_q, err_d;
  logic                   crc_bit_q, crc_bit_d, crc_en_q, crc_en_d;
  logic [1:0]             pkt_in_q, pkt_in_d, pkt_type_q, pkt_type_d;
  logic [TOK_BITS+7:0]    token_q, token_d;
  logic [DATA_BITS+7:0]   data_q, data_d;
  logic [7:0]             hshake_q, hshake_d;
  logic                   pkt_valid_q, pkt_valid_d, pkt_err_q, pkt_err_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [6:0]             exp_len, pay_len;
  logic                   pid_chk_ok, rep_good, rep_err;
  logic [1:0]             rep_code;

  assign win_sh = {win_q[6:0], s_in};
  assign pid_sh = {pid_q[6:0], s_in};

`ifdef BS_DEC_PID_CHECK_EN
  assign pid_chk_ok = (pid_sh[7:4] == ~pid_sh[3:0]);
`else
  assign pid_chk_ok = 1'b1;
`endif

  always_comb begin
    exp_len = '0;
    pay_len = '0;
    case (pid_q[1:0])
      T_TOK:   begin exp_len = TOK_LEN;  pay_len = TOK_PAY;  end
      T_DATA:  begin exp_len = DATA_LEN; pay_len = DATA_PAY; end
      default: begin exp_len = '0;       pay_len = '0;       end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    pid_d     = pid_q;
    pay_d     = pay_q;
    err_d     = err_q;
    crc_bit_d = 1'b0;
    crc_en_d  = 1'b0;
    pkt_in_d  = '0;
    rep_good  = 1'b0;
    rep_err   = 1'b0;
    rep_code  = err_q;
    case (state_q)
      HUNT: begin
        if (s_valid && !eop) begin
          win_d = win_sh;
          if (win_sh == SYNC_PAT) begin
            win_d   = '0;
            cnt_d   = '0;
            state_d = PID;
          end
        end
      end
      PID: begin
        if (eop) begin
          rep_err  = 1'b1;
          rep_code = ERR_LEN;
          win_d    = '0;
          state_d  = HUNT;
        end else if (s_valid) begin
          pid_d = pid_sh;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == 7'd7) begin
            cnt_d = '0;
            if (pid_sh[1:0] == 2'b00 || !pid_chk_ok) begin
              err_d   = ERR_PID;
              state_d = DRAIN;
            end else begin
              pkt_in_d = pid_sh[1:0];
              state_d  = PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        if (eop) begin
          win_d   = '0;
          state_d = HUNT;
          if (cnt_q != exp_len) begin
            rep_err  = 1'b1;
            rep_code = ERR_LEN;
          end else if (exp_len != '0 && !crc_ok) begin
            rep_err  = 1'b1;
            rep_code = ERR_CRC;
          end else begin
            rep_good = 1'b1;
          end
        end else if (s_valid) begin
          crc_bit_d = s_in;
          crc_en_d  = 1'b1;
          cnt_d     = cnt_q + 7'd1;
          if (cnt_q < pay_len) pay_d = {pay_q[DATA_BITS-2:0], s_in};
          // this bit makes the count exp_len+1: one bit too many
          if (cnt_q == exp_len) begin
            err_d   = ERR_LEN;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (eop) begin
          rep_err = 1'b1;
          win_d   = '0;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    pkt_valid_d = rep_good;
    pkt_err_d   = rep_err;
    err_code_d  = rep_err ? rep_code : 2'b00;
    pkt_type_d  = pkt_type_q;
    token_d     = token_q;
    data_d      = data_q;
    hshake_d    = hshake_q;
    if (rep_good) begin
      pkt_type_d = pid_q[1:0];
      case (pid_q[1:0])
        T_TOK:   token_d  = {pid_q, pay_q[TOK_BITS-1:0]};
        T_DATA:  data_d   = {pid_q, pay_q};
        default: hshake_d = pid_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      win_q       <= '0;
      cnt_q       <= '0;
      pid_q       <= '0;
      pay_q       <= '0;
      err_q       <= '0;
      crc_bit_q   <= 1'b0;
      crc_en_q    <= 1'b0;
      pkt_in_q    <= '0;
      pkt_type_q  <= '0;
      token_q     <= '0;
      data_q      <= '0;
      hshake_q    <= '0;
      pkt_valid_q <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      pid_q       <= pid_d;
      pay_q       <= pay_d;
      err_q       <= err_d;
      crc_bit_q   <= crc_bit_d;
      crc_en_q    <= crc_en_d;
      pkt_in_q    <= pkt_in_d;
      pkt_type_q  <= pkt_type_d;
      token_q     <= token_d;
      data_q      <= data_d;
      hshake_q    <= hshake_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign crc_bit   = crc_bit_q;
  assign crc_en    = crc_en_q;
  assign pkt_in    = pkt_in_q;
  assign pkt_type  = pkt_type_q;
  assign token     = token_q;
  assign data      = data_q;
  assign hshake    = hshake_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != HUNT);

endmodule
